// File: rtl/mem_pkg.sv
// Shared types and constants for the data-side memory responder.
package mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LANE_BITS  = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    MT_B  = 3'b000,
    MT_H  = 3'b001,
    MT_W  = 3'b010,
    MT_BU = 3'b100,
    MT_HU = 3'b101
  } mem_type_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW
  } state_t;

  function automatic logic type_legal(input logic [2:0] t);
    return (t == MT_B) || (t == MT_H) || (t == MT_W) || (t == MT_BU) || (t == MT_HU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extends a loaded lane and merges a store lane into an old word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0]          word_i,
  input  logic [31:0]          new_i,
  input  logic [LANE_BITS-1:0] off_i,
  input  logic [2:0]           type_i,
  output logic [31:0]          load_o,
  output logic [31:0]          merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_o = word_i;
    case (type_i)
      MT_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      MT_BU:   load_o = {24'h0, byte_sel};
      MT_H:    load_o = {{16{half_sel[15]}}, half_sel};
      MT_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merged_o = word_i;
    case (type_i)
      MT_B, MT_BU: begin
        case (off_i)
          2'd1:    merged_o[15:8]  = new_i[7:0];
          2'd2:    merged_o[23:16] = new_i[7:0];
          2'd3:    merged_o[31:24] = new_i[7:0];
          default: merged_o[7:0]   = new_i[7:0];
        endcase
      end
      MT_H, MT_HU: begin
        if (off_i[1]) merged_o[31:16] = new_i[15:0];
        else          merged_o[15:0]  = new_i[15:0];
      end
      default: merged_o = new_i;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data port to single-port synchronous SRAM: sized loads with extension, word stores,
// and read-modify-write for byte/halfword stores.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic [31:0]       MEM_addr,
  input  logic [31:0]       MEM_WR_out,
  input  logic [2:0]        MEM_type,
  input  logic              MEM_rd_en,
  input  logic              MEM_wr_en,
  output logic [31:0]       MEM_data,
  output logic              MEM_valid,
  output logic              MEM_ready,
  output logic              MEM_err,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output state_t            dbg_state_o
);

  // Handshake: a request is taken in any cycle where MEM_ready=1 and rd_en|wr_en is high;
  // the CPU holds its request while MEM_ready=0. MEM_valid/MEM_err are single-cycle pulses.

  state_t               state_q, state_d;
  logic [31:0]          data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [LANE_BITS-1:0] off_q, off_d;
  logic [2:0]           type_q, type_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [ADDR_W-3:0]    waddr_q, waddr_d;

  logic        req, reject, misaligned, out_of_range;
  logic [31:0] load_ext, merged;

  assign req          = MEM_rd_en | MEM_wr_en;
  assign misaligned   = (((MEM_type == MT_H) || (MEM_type == MT_HU)) && MEM_addr[0]) ||
                        ((MEM_type == MT_W) && (MEM_addr[LANE_BITS-1:0] != '0));
  assign out_of_range = |MEM_addr[31:ADDR_W];
  assign reject       = (MEM_rd_en & MEM_wr_en) | ~type_legal(MEM_type) | misaligned | out_of_range;

  // One aligner serves both the load return and the RMW merge; both use the latched request.
  mem_lane_align u_align (
    .word_i   (sram_rdata),
    .new_i    (wdata_q),
    .off_i    (off_q),
    .type_i   (type_q),
    .load_o   (load_ext),
    .merged_o (merged)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    off_d      = off_q;
    type_d     = type_q;
    wdata_d    = wdata_q;
    waddr_d    = waddr_q;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = waddr_q;
    sram_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            sram_en   = 1'b1;
            sram_addr = MEM_addr[ADDR_W-1:LANE_BITS];
            off_d     = MEM_addr[LANE_BITS-1:0];
            type_d    = MEM_type;
            wdata_d   = MEM_WR_out;
            waddr_d   = MEM_addr[ADDR_W-1:LANE_BITS];
            if (MEM_rd_en) begin
              state_d = RD_WAIT;
            end else if (MEM_type == MT_W) begin
              sram_we    = 1'b1;
              sram_wdata = MEM_WR_out;
            end else begin
              state_d = RMW;
            end
          end
        end
      end
      RD_WAIT: begin
        data_d  = load_ext;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      RMW: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_wdata = merged;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= '0;
      type_q  <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      off_q   <= off_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end

  assign MEM_data    = data_q;
  assign MEM_valid   = valid_q;
  assign MEM_err     = err_q;
  assign MEM_ready   = (state_q == IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed vectors plus an aligned random stream.
module tb_data_mem_responder;

  localparam int ADDR_W = 12;
  localparam int EXP_W  = 65;   // {is_err, data, due_cycle}
  localparam int WR_W   = 42;   // {word_addr, word}
  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  logic              CLK = 1'b0;
  logic              Reset_n = 1'b0;
  logic [31:0]       MEM_addr = '0;
  logic [31:0]       MEM_WR_out = '0;
  logic [2:0]        MEM_type = '0;
  logic              MEM_rd_en = 1'b0;
  logic              MEM_wr_en = 1'b0;
  logic [31:0]       MEM_data;
  logic              MEM_valid, MEM_ready, MEM_err;
  logic              sram_en, sram_we;
  logic [ADDR_W-3:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata = '0;
  mem_pkg::state_t   dbg_state;

  logic [31:0]      sram_mem [1024];
  logic [7:0]       ref_mem [4096];
  logic [EXP_W-1:0] exp_q[$];
  logic [WR_W-1:0]  wr_q[$];
  logic [2:0]       types [5] = '{T_B, T_H, T_W, T_BU, T_HU};
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  data_mem_responder #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .MEM_addr(MEM_addr), .MEM_WR_out(MEM_WR_out),
    .MEM_type(MEM_type), .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en),
    .MEM_data(MEM_data), .MEM_valid(MEM_valid), .MEM_ready(MEM_ready), .MEM_err(MEM_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / SRAM macro ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected no event", name, act);
  endtask

  // ---------------- reference byte memory ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] t);
    logic [11:0] x;
    logic [7:0]  b;
    logic [15:0] h;
    x = a[11:0];
    b = ref_mem[x];
    h = {ref_mem[x + 12'd1], ref_mem[x]};
    case (t)
      T_B:     return {{24{b[7]}}, b};
      T_BU:    return {24'h0, b};
      T_H:     return {{16{h[15]}}, h};
      T_HU:    return {16'h0, h};
      default: return {ref_mem[x + 12'd3], ref_mem[x + 12'd2], h};
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] wd);
    logic [11:0] x;
    x = a[11:0];
    ref_mem[x] = wd[7:0];
    if (t != T_B && t != T_BU) ref_mem[x + 12'd1] = wd[15:8];
    if (t == T_W) begin
      ref_mem[x + 12'd2] = wd[23:16];
      ref_mem[x + 12'd3] = wd[31:24];
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [11:0] x;
    x = {a[11:2], 2'b00};
    return {ref_mem[x + 12'd3], ref_mem[x + 12'd2], ref_mem[x + 12'd1], ref_mem[x]};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [EXP_W-1:0] mon_e;
  logic [WR_W-1:0]  mon_w;

  always @(negedge CLK) begin
    if (MEM_valid && MEM_err) fail("valid_err_same_cycle", {30'h0, MEM_valid, MEM_err});
    if (MEM_valid || MEM_err) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_response", MEM_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_is_err", 32'(MEM_err), 32'(mon_e[64]));
        chk("resp_data", MEM_data, mon_e[63:32]);
        chk("resp_cycle", cyc, mon_e[31:0]);
      end
    end
    if (sram_en && sram_we) begin
      if (wr_q.size() == 0) begin
        fail("unexpected_sram_write", sram_wdata);
      end else begin
        mon_w = wr_q.pop_front();
        chk("sram_write_addr", 32'(sram_addr), 32'(mon_w[41:32]));
        chk("sram_write_data", sram_wdata, mon_w[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // exp_val: load result, stored word, or held MEM_data for a rejected request.
  task automatic do_req(input bit rd, input bit wr, input logic [2:0] t, input logic [31:0] addr,
                        input logic [31:0] wd, input bit is_err, input logic [31:0] exp_val);
    int acc;
    bit stall;
    @(posedge CLK); #1;
    chk("ready_before_req", 32'(MEM_ready), 32'd1);
    MEM_rd_en = rd; MEM_wr_en = wr; MEM_type = t; MEM_addr = addr; MEM_WR_out = wd;
    acc   = cyc;
    stall = !is_err && (rd || t != T_W);
    if (is_err)  exp_q.push_back({1'b1, exp_val, 32'(acc + 1)});
    else if (rd) exp_q.push_back({1'b0, exp_val, 32'(acc + 2)});
    else         wr_q.push_back({addr[ADDR_W-1:2], exp_val});
    @(negedge CLK);
    chk("c0_sram_en", 32'(sram_en), 32'(!is_err));
    if (!is_err) begin
      chk("c0_sram_addr", 32'(sram_addr), 32'(addr[ADDR_W-1:2]));
      chk("c0_sram_we", 32'(sram_we), 32'(wr && t == T_W));
    end
    @(posedge CLK); #1;
    MEM_rd_en = 1'b0; MEM_wr_en = 1'b0;
    @(negedge CLK);
    chk("c1_ready", 32'(MEM_ready), 32'(!stall));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;

    repeat (3) @(posedge CLK);
    #1 Reset_n = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("idle_ready", 32'(MEM_ready), 32'd1);
      chk("idle_data", MEM_data, 32'h0);
      chk("idle_sram_en", 32'(sram_en), 32'd0);
    end

    do_req(0, 1, T_W,  32'h010, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    do_req(1, 0, T_W,  32'h010, 32'h0,        0, 32'hDEADBEEF);
    do_req(0, 1, T_B,  32'h011, 32'h00000055, 0, 32'hDEAD55EF);
    do_req(1, 0, T_B,  32'h013, 32'h0,        0, 32'hFFFFFFDE);
    do_req(1, 0, T_BU, 32'h013, 32'h0,        0, 32'h000000DE);
    do_req(1, 0, T_H,  32'h012, 32'h0,        0, 32'hFFFFDEAD);
    do_req(1, 0, T_HU, 32'h010, 32'h0,        0, 32'h000055EF);

    do_req(1, 0, T_W,    32'h012,      32'h0,    1, 32'h000055EF);
    do_req(0, 1, T_H,    32'h011,      32'h1234, 1, 32'h000055EF);
    do_req(1, 0, T_W,    32'h00001000, 32'h0,    1, 32'h000055EF);
    do_req(1, 1, T_W,    32'h010,      32'h0,    1, 32'h000055EF);
    do_req(1, 0, 3'b011, 32'h010,      32'h0,    1, 32'h000055EF);
    do_req(1, 0, T_W,    32'h010,      32'h0,    0, 32'hDEAD55EF);

    // Reset lands in the RMW cycle of a halfword store; the old word must survive.
    do_req(0, 1, T_W, 32'h020, 32'h12345678, 0, 32'h12345678);
    @(posedge CLK); #1;
    chk("rmw_ready_before", 32'(MEM_ready), 32'd1);
    MEM_wr_en = 1'b1; MEM_type = T_H; MEM_addr = 32'h020; MEM_WR_out = 32'h0000ABCD;
    @(posedge CLK); #1;
    MEM_wr_en = 1'b0;
    Reset_n = 1'b0;
    @(negedge CLK);
    chk("rst_rmw_we", 32'(sram_we), 32'd0);
    chk("rst_rmw_ready", 32'(MEM_ready), 32'd1);
    chk("rst_rmw_data", MEM_data, 32'h0);
    @(posedge CLK); #1;
    Reset_n = 1'b1;
    do_req(1, 0, T_W, 32'h020, 32'h0, 0, 32'h12345678);

    for (int i = 0; i < 100; i++) begin
      logic [2:0]  t;
      logic [31:0] a, wd;
      int k, off;
      bit rd;
      k   = int'($urandom_range(0, 4));
      t   = types[k];
      off = (t == T_W) ? 0 : (t == T_H || t == T_HU) ? 2 * int'($urandom_range(0, 1))
                                                     : int'($urandom_range(0, 3));
      a   = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4 + 32'(off);
      rd  = ($urandom_range(0, 1) == 1);
      wd  = $urandom;
      if (rd) begin
        do_req(1, 0, t, a, 32'h0, 0, ref_load(a, t));
      end else begin
        ref_store(a, t, wd);
        do_req(0, 1, t, a, wd, 0, ref_word(a));
      end
    end

    repeat (4) @(posedge CLK);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
